// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, bit-period divider, frame width.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  function automatic int unsigned calc_div(input int unsigned clk_frec,
                                           input int unsigned baudrate);
    return clk_frec / baudrate;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset value is a parameter.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/uart_rx_deser.sv
// 8N1 UART receive deserializer: recovers bytes from rx and pushes them to the RX FIFO,
// flagging framing errors and overruns with one-cycle pulses.
module uart_rx_deser
  import uart_pkg::*;
#(
  parameter int unsigned baudrate = 9600,
  parameter int unsigned clk_frec = 100_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  input  logic                      fifo_full,
  output logic                      push,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      frame_err,
  output logic                      overrun,
  output logic                      busy
);

  localparam int unsigned DIV  = calc_div(clk_frec, baudrate);
  localparam int unsigned HALF = DIV / 2;
  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;

  logic                      w_rx_s;
  rx_state_t                 r_state;
  logic [CW-1:0]             r_cnt;
  logic [2:0]                r_bit;
  logic [UART_DATA_BITS-1:0] r_shift;

  // Idle-high reset value keeps a reset release from looking like a start edge.
  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rx),
    .o_q (w_rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_shift   <= '0;
      rx_data   <= '0;
      push      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      push      <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state <= START;
            r_cnt   <= '0;
          end
        end
        START: begin
          if (r_cnt == CW'(HALF - 1)) begin
            r_cnt <= '0;
            r_bit <= '0;
            r_state <= w_rx_s ? IDLE : DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (r_cnt == CW'(DIV - 1)) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
            if (r_bit == 3'(UART_DATA_BITS - 1)) r_state <= STOP;
            else                                 r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        STOP: begin
          if (r_cnt == CW'(DIV - 1)) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              rx_data <= r_shift;
              if (fifo_full) overrun <= 1'b1;
              else           push    <= 1'b1;
              r_state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              r_state   <= WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (w_rx_s) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state != IDLE);

endmodule
